ahb3lite_interconnect_slave_port: RTL and testbench

//  Slave-side stage of the AHB3-Lite multi-layer switch; one instance per AHB slave. Collects requests from all master ports,

---
 rtl/ahb3lite_interconnect_slave_port.sv | 136 +++++++++++++
 tb/tb_ahb3lite_interconnect_slave_port.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_interconnect_slave_port.sv
// Slave-side stage of the AHB3-Lite multi-layer switch: priority arbitration, address/data muxing, response broadcast.
// Optional round-robin tie breaking among equal priorities is enabled by defining AHB3LITE_SLVPORT_RR_EN.
module ahb3lite_interconnect_slave_port #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MASTERS    = 3
) (
  input  logic                                 HCLK,
  input  logic                                 HRESETn,
  input  logic [MASTERS-1:0][2:0]              mstpriority,
  input  logic [MASTERS-1:0]                   mstHSEL,
  input  logic [MASTERS-1:0][HADDR_SIZE-1:0]   mstHADDR,
  input  logic [MASTERS-1:0][HDATA_SIZE-1:0]   mstHWDATA,
  input  logic [MASTERS-1:0]                   mstHWRITE,
  input  logic [MASTERS-1:0][2:0]              mstHSIZE,
  input  logic [MASTERS-1:0][2:0]              mstHBURST,
  input  logic [MASTERS-1:0][3:0]              mstHPROT,
  input  logic [MASTERS-1:0][1:0]              mstHTRANS,
  input  logic [MASTERS-1:0]                   mstHMASTLOCK,
  input  logic [MASTERS-1:0]                   mstHREADY,
  input  logic [MASTERS-1:0]                   can_switch,
  output logic [MASTERS-1:0]                   master_granted,
  output logic [HDATA_SIZE-1:0]                mstHRDATA,
  output logic                                 mstHREADYOUT,
  output logic                                 mstHRESP,
  output logic                                 HSEL,
  output logic [HADDR_SIZE-1:0]                HADDR,
  output logic [HDATA_SIZE-1:0]                HWDATA,
  output logic                                 HWRITE,
  output logic [2:0]                           HSIZE,
  output logic [2:0]                           HBURST,
  output logic [3:0]                           HPROT,
  output logic [1:0]                           HTRANS,
  output logic                                 HMASTLOCK,
  input  logic [HDATA_SIZE-1:0]                HRDATA,
  input  logic                                 HREADYOUT,
  input  logic                                 HRESP,
  output logic                                 HREADY
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [MASTERS-1:0] r_gnt;
  logic [MASTERS-1:0] r_dgnt;
  logic [MASTERS-1:0] w_winner;
  logic [IW-1:0]      w_owner;
  logic [IW-1:0]      w_downer;
  logic [IW-1:0]      w_start;
  logic [IW-1:0]      w_idx;
  logic [IW:0]        w_idx_ext;
  logic [2:0]         w_best;
  logic               w_found;
  logic               w_locked;
  logic               w_switch;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_owner  = '0;
    w_downer = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (r_gnt[i])  w_owner  |= IW'(i);
      if (r_dgnt[i]) w_downer |= IW'(i);
    end
  end

`ifdef AHB3LITE_SLVPORT_RR_EN
  // Ties rotate: search begins just after the last owner (the parked grant is that owner).
  assign w_start = (~|r_gnt || w_owner == IW'(MASTERS - 1)) ? '0 : w_owner + 1'b1;
`else
  assign w_start = '0;
`endif

  // Strict '>' means the first requester met in search order keeps a tie.
  always_comb begin
    w_winner  = '0;
    w_best    = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    w_idx_ext = '0;
    for (int i = 0; i < MASTERS; i++) begin
      w_idx_ext = {1'b0, w_start} + (IW + 1)'(i);
      if (w_idx_ext >= (IW + 1)'(MASTERS)) w_idx_ext = w_idx_ext - (IW + 1)'(MASTERS);
      w_idx = w_idx_ext[IW-1:0];
      if (mstHSEL[w_idx] && (!w_found || mstpriority[w_idx] > w_best)) begin
        w_found         = 1'b1;
        w_best          = mstpriority[w_idx];
        w_winner        = '0;
        w_winner[w_idx] = 1'b1;
      end
    end
  end

  assign w_locked = (|r_gnt) & mstHMASTLOCK[w_owner] & mstHSEL[w_owner];
  assign w_switch = HREADYOUT & (~|r_gnt | can_switch[w_owner] | ~mstHSEL[w_owner]) & ~w_locked;

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_gnt  <= '0;
      r_dgnt <= '0;
    end else begin
      if (w_switch && w_found) r_gnt <= w_winner;
      if (HREADY && HREADYOUT) r_dgnt <= HSEL ? r_gnt : '0;
    end
  end

  always_comb begin
    HSEL      = 1'b0;
    HADDR     = '0;
    HWRITE    = 1'b0;
    HSIZE     = '0;
    HBURST    = '0;
    HPROT     = '0;
    HTRANS    = 2'b00;
    HMASTLOCK = 1'b0;
    HREADY    = 1'b1;
    if (|r_gnt) begin
      HSEL      = mstHSEL[w_owner];
      HADDR     = mstHADDR[w_owner];
      HWRITE    = mstHWRITE[w_owner];
      HSIZE     = mstHSIZE[w_owner];
      HBURST    = mstHBURST[w_owner];
      HPROT     = mstHPROT[w_owner];
      HTRANS    = mstHSEL[w_owner] ? mstHTRANS[w_owner] : 2'b00;
      HMASTLOCK = mstHMASTLOCK[w_owner];
      HREADY    = mstHREADY[w_owner];
    end
  end

  assign HWDATA         = (|r_dgnt) ? mstHWDATA[w_downer] : '0;
  assign master_granted = r_gnt;
  assign mstHRDATA      = HRDATA;
  assign mstHREADYOUT   = HREADYOUT;
  assign mstHRESP       = HRESP;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
// Scoreboard bench for ahb3lite_interconnect_slave_port: directed cycles push expected outputs, a monitor compares at negedge.
module tb_ahb3lite_interconnect_slave_port;

  localparam logic [2:0][31:0] ADDR   = {32'h3000_0040, 32'h2000_0020, 32'h1000_0010};
  localparam logic [2:0][31:0] WDATA  = {32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
  localparam logic [2:0][2:0]  BURST  = {3'd3, 3'd1, 3'd0};
  localparam logic [2:0]       HWRV   = 3'b101;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [2:0][2:0]  pri;
  logic [2:0]       req, cs, lock;
  logic [2:0][1:0]  trans;
  logic [2:0][2:0]  hsize_v;
  logic [2:0][3:0]  hprot_v;
  logic             slv_ready, slv_resp;
  logic [31:0]      slv_rdata;

  logic [2:0]       master_granted;
  logic [31:0]      mstHRDATA, HADDR, HWDATA;
  logic             mstHREADYOUT, mstHRESP, HSEL, HWRITE, HMASTLOCK, HREADY;
  logic [2:0]       HSIZE, HBURST;
  logic [3:0]       HPROT;
  logic [1:0]       HTRANS;

  always #5 HCLK = ~HCLK;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      trans[i]   = req[i] ? 2'b10 : 2'b00;
      hsize_v[i] = 3'b010;
      hprot_v[i] = 4'b0011;
    end
  end

  ahb3lite_interconnect_slave_port #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .mstpriority(pri), .mstHSEL(req), .mstHADDR(ADDR), .mstHWDATA(WDATA),
    .mstHWRITE(HWRV), .mstHSIZE(hsize_v), .mstHBURST(BURST), .mstHPROT(hprot_v),
    .mstHTRANS(trans), .mstHMASTLOCK(lock), .mstHREADY({3{slv_ready}}), .can_switch(cs),
    .master_granted(master_granted), .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT),
    .mstHRESP(mstHRESP), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HRDATA(slv_rdata), .HREADYOUT(slv_ready), .HRESP(slv_resp), .HREADY(HREADY)
  );

  typedef struct {
    string       name;
    logic [2:0]  gnt;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cyc    = 0;

  task automatic check(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h expected=%h t=%0t", name, field, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [2:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Expected bus view for this cycle, given the hand-derived address owner and data owner.
  task automatic exp_cyc(input string name, input logic [2:0] eg, input logic [2:0] ed);
    exp_t e;
    int   o, d;
    o = onehot_idx(eg);
    d = onehot_idx(ed);
    e.name      = name;
    e.gnt       = eg;
    e.hsel      = (eg != 0) ? req[o] : 1'b0;
    e.haddr     = (eg != 0) ? ADDR[o] : 32'h0;
    e.hwrite    = (eg != 0) ? HWRV[o] : 1'b0;
    e.hburst    = (eg != 0) ? BURST[o] : 3'd0;
    e.hmastlock = (eg != 0) ? lock[o] : 1'b0;
    e.htrans    = e.hsel ? 2'b10 : 2'b00;
    e.hwdata    = (ed != 0) ? WDATA[d] : 32'h0;
    e.hready    = (eg != 0) ? slv_ready : 1'b1;
    e.hreadyout = slv_ready;
    e.hresp     = slv_resp;
    e.hrdata    = slv_rdata;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
    n_cyc++;
    slv_rdata = 32'hD00D_0000 | 32'(n_cyc);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, "gnt",       32'(master_granted), 32'(e.gnt));
        check(e.name, "hsel",      32'(HSEL),           32'(e.hsel));
        check(e.name, "haddr",     HADDR,               e.haddr);
        check(e.name, "htrans",    32'(HTRANS),         32'(e.htrans));
        check(e.name, "hwrite",    32'(HWRITE),         32'(e.hwrite));
        check(e.name, "hburst",    32'(HBURST),         32'(e.hburst));
        check(e.name, "hmastlock", 32'(HMASTLOCK),      32'(e.hmastlock));
        check(e.name, "hwdata",    HWDATA,              e.hwdata);
        check(e.name, "hready",    32'(HREADY),         32'(e.hready));
        check(e.name, "hreadyout", 32'(mstHREADYOUT),   32'(e.hreadyout));
        check(e.name, "hresp",     32'(mstHRESP),       32'(e.hresp));
        check(e.name, "hrdata",    mstHRDATA,           e.hrdata);
      end
    end
  end

`ifdef AHB3LITE_SLVPORT_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  initial begin : stimulus
    HRESETn = 1'b0; req = '0; cs = '0; lock = '0; pri = '0;
    slv_ready = 1'b1; slv_resp = 1'b0; slv_rdata = '0;

    next_cycle(); exp_cyc("reset", 3'b000, 3'b000);
    // single requester
    next_cycle(); HRESETn = 1'b1; req = 3'b001; pri[0] = 3'd1; exp_cyc("m0_req", 3'b000, 3'b000);
    next_cycle(); exp_cyc("m0_grant", 3'b001, 3'b000);
    next_cycle(); req = 3'b000; exp_cyc("m0_data", 3'b001, 3'b001);
    next_cycle(); exp_cyc("park", 3'b001, 3'b000);
    // priority and can_switch
    next_cycle(); req = 3'b101; pri[2] = 3'd5; cs = 3'b001; exp_cyc("m0_m2_req", 3'b001, 3'b000);
    next_cycle(); cs = 3'b000; exp_cyc("m2_grant", 3'b100, 3'b001);
    next_cycle(); pri[0] = 3'd7; exp_cyc("pri_change_held", 3'b100, 3'b100);
    next_cycle(); cs = 3'b100; exp_cyc("m2_switchable", 3'b100, 3'b100);
    next_cycle(); req = 3'b000; cs = 3'b111; exp_cyc("m0_pri7_win", 3'b001, 3'b100);
    next_cycle(); exp_cyc("idle2", 3'b001, 3'b000);
    // equal priority ties
    next_cycle(); req = 3'b111; pri = {3'd3, 3'd3, 3'd3}; exp_cyc("tie0", 3'b001, 3'b000);
    next_cycle(); exp_cyc("tie1", RR ? 3'b010 : 3'b001, 3'b001);
    next_cycle(); exp_cyc("tie2", RR ? 3'b100 : 3'b001, RR ? 3'b010 : 3'b001);
    next_cycle(); exp_cyc("tie3", 3'b001, RR ? 3'b100 : 3'b001);
    next_cycle(); req = 3'b000; exp_cyc("tie_end", RR ? 3'b010 : 3'b001, 3'b001);
    // locked sequence
    next_cycle(); req = 3'b010; pri[1] = 3'd2; exp_cyc("m1_req", RR ? 3'b010 : 3'b001, 3'b000);
    next_cycle(); req = 3'b011; lock = 3'b010; pri[0] = 3'd7; cs = 3'b111;
                  exp_cyc("lock0", 3'b010, RR ? 3'b010 : 3'b000);
    next_cycle(); exp_cyc("lock1", 3'b010, 3'b010);
    next_cycle(); exp_cyc("lock2", 3'b010, 3'b010);
    next_cycle(); lock = 3'b000; cs = 3'b010; exp_cyc("unlock", 3'b010, 3'b010);
    next_cycle(); req = 3'b000; cs = 3'b111; exp_cyc("m0_after_unlock", 3'b001, 3'b010);
    next_cycle(); exp_cyc("idle3", 3'b001, 3'b000);
    // slave wait states and two-cycle error
    next_cycle(); req = 3'b001; pri[0] = 3'd1; exp_cyc("m0_req2", 3'b001, 3'b000);
    next_cycle(); req = 3'b101; pri[2] = 3'd7; slv_ready = 1'b0; exp_cyc("wait0", 3'b001, 3'b001);
    next_cycle(); exp_cyc("wait1", 3'b001, 3'b001);
    next_cycle(); slv_resp = 1'b1; exp_cyc("wait2_err", 3'b001, 3'b001);
    next_cycle(); slv_ready = 1'b1; exp_cyc("err_end", 3'b001, 3'b001);
    next_cycle(); slv_resp = 1'b0; cs = 3'b000; exp_cyc("m2_after_wait", 3'b100, 3'b001);
    next_cycle(); exp_cyc("m2_data", 3'b100, 3'b100);
    // asynchronous reset during a data phase
    next_cycle(); HRESETn = 1'b0; exp_cyc("async_reset", 3'b000, 3'b000);
    next_cycle(); HRESETn = 1'b1; req = 3'b000; exp_cyc("reset_release", 3'b000, 3'b000);

    repeat (2) @(posedge HCLK);
    check("scoreboard", "pending", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
